// File: rtl/n_bit_serial_subtractor.sv
// Bit-serial N-bit subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single full-subtractor cell, with a start/busy/done handshake.
module n_bit_serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ov
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   a_sh_reg, b_sh_reg, work_reg;
  logic           br_reg, bmsb_reg;
  logic [CW-1:0]  cnt_reg;
  logic           a_i, b_i, d, br_next, last, accept;

  assign a_i     = a_sh_reg[0];
  assign b_i     = b_sh_reg[0];
  assign d       = a_i ^ b_i ^ br_reg;
  assign br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br_reg);
  assign last    = (cnt_reg == CW'(N - 1));

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // work_reg collects the shifting difference so diff only changes at DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh_reg <= '0;
      b_sh_reg <= '0;
      work_reg <= '0;
      br_reg   <= 1'b0;
      bmsb_reg <= 1'b0;
      cnt_reg  <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      ov       <= 1'b0;
    end else if (accept) begin
      a_sh_reg <= a;
      b_sh_reg <= b;
      br_reg   <= bin;
      cnt_reg  <= '0;
    end else if (state_reg == RUN) begin
      a_sh_reg <= a_sh_reg >> 1;
      b_sh_reg <= b_sh_reg >> 1;
      work_reg <= {d, work_reg[N-1:1]};
      br_reg   <= br_next;
      cnt_reg  <= cnt_reg + 1'b1;
      if (cnt_reg == CW'(N - 2)) bmsb_reg <= br_next;
      // Signed overflow: borrow into the sign bit differs from borrow out of it.
      if (last) begin
        diff <= {d, work_reg[N-1:1]};
        bout <= br_next;
        ov   <= bmsb_reg ^ br_next;
      end
    end
  end

endmodule

// File: tb/tb_n_bit_serial_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor at N=8 and N=32.
module tb_n_bit_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, bin8, busy8, done8, bout8, ov8;
  logic [7:0] a8, b8, diff8;
  logic        start32, bin32, busy32, done32, bout32, ov32;
  logic [31:0] a32, b32, diff32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  n_bit_serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ov(ov8)
  );

  n_bit_serial_subtractor #(.N(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32), .bin(bin32),
    .busy(busy32), .done(done32), .diff(diff32), .bout(bout32), .ov(ov32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One N=8 operation; optionally pulses start with other operands at RUN cycle pulse_at.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                     input logic [7:0] ed, input logic eb, input logic eo, input int pulse_at);
    int n, bc, both;
    @(negedge clk);
    a8 = ta; b8 = tb_v; bin8 = tbin; start8 = 1'b1;
    n = 0; bc = 0; both = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin start8 = 1'b0; a8 = ~ta; b8 = 8'h5A; bin8 = ~tbin; end
      if (pulse_at != 0 && n == pulse_at) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; end
      if (pulse_at != 0 && n == pulse_at + 1) start8 = 1'b0;
      if (busy8) bc++;
      if (busy8 && done8) both++;
    end while (!done8 && n < 30);
    check({tag, " latency"}, n, 9);
    check({tag, " busy_cycles"}, bc, 8);
    check({tag, " busy_done_overlap"}, both, 0);
    check({tag, " diff"}, diff8, ed);
    check({tag, " bout"}, bout8, eb);
    check({tag, " ov"}, ov8, eo);
    $display("op8 %s: a=%02h b=%02h bin=%0d -> diff=%02h bout=%0d ov=%0d latency=%0d",
             tag, ta, tb_v, tbin, diff8, bout8, ov8, n);
  endtask

  task automatic op32(input int idx, input logic [31:0] ta, input logic [31:0] tb_v, input logic tbin);
    logic [32:0] full;
    logic        eo;
    int          n;
    full = {1'b0, ta} - {1'b0, tb_v} - {32'd0, tbin};
    eo   = (ta[31] ^ tb_v[31]) & (full[31] ^ ta[31]);
    @(negedge clk);
    a32 = ta; b32 = tb_v; bin32 = tbin; start32 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin start32 = 1'b0; a32 = $urandom; b32 = $urandom; end
    end while (!done32 && n < 60);
    check($sformatf("r32[%0d] latency", idx), n, 33);
    check($sformatf("r32[%0d] diff", idx), diff32, full[31:0]);
    check($sformatf("r32[%0d] bout", idx), bout32, full[32]);
    check($sformatf("r32[%0d] ov", idx), ov32, eo);
  endtask

  logic [7:0] pa [5] = '{8'h05, 8'h00, 8'h80, 8'h7F, 8'h10};
  logic [7:0] pb [5] = '{8'h03, 8'h01, 8'h01, 8'hFF, 8'h0F};
  logic       pi [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] pd [5] = '{8'h02, 8'hFF, 8'h7F, 8'h80, 8'h00};
  logic       pbo[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic       pov[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int n, dones;
    bit stable;
    reset = 1'b1; start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    start32 = 0; a32 = 0; b32 = 0; bin32 = 0;
    repeat (3) @(negedge clk);
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset diff", diff8, 0);
    check("reset bout", bout8, 0);
    check("reset ov", ov8, 0);
    check("reset diff32", diff32, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++)
      op8($sformatf("vec%0d", i), pa[i], pb[i], pi[i], pd[i], pbo[i], pov[i], 0);

    // Back-to-back: start held high, new operands presented at each done.
    @(negedge clk);
    a8 = pa[0]; b8 = pb[0]; bin8 = pi[0]; start8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0; stable = 1'b1;
      do begin
        @(negedge clk);
        n++;
        if (!done8 && i > 0 && diff8 !== pd[i-1]) stable = 1'b0;
      end while (!done8 && n < 30);
      check($sformatf("b2b[%0d] interval", i), n, 9);
      check($sformatf("b2b[%0d] diff", i), diff8, pd[i]);
      check($sformatf("b2b[%0d] bout", i), bout8, pbo[i]);
      check($sformatf("b2b[%0d] ov", i), ov8, pov[i]);
      if (i > 0) check($sformatf("b2b[%0d] diff_stable", i), stable, 1);
      $display("b2b %0d: diff=%02h bout=%0d ov=%0d interval=%0d", i, diff8, bout8, ov8, n);
      if (i < 4) begin a8 = pa[i+1]; b8 = pb[i+1]; bin8 = pi[i+1]; end
      else start8 = 1'b0;
    end
    @(negedge clk);
    check("b2b idle_after", done8, 0);

    // start during RUN must be neither honoured nor queued.
    op8("ignore", 8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0, 3);
    dones = 0;
    repeat (12) begin @(negedge clk); if (done8) dones++; end
    check("ignore no_queued_done", dones, 0);

    // Reset mid-operation abandons it.
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h10; bin8 = 1'b0; start8 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start8 = 1'b0;
      if (k == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; end
      if (k == 4) start8 = 1'b0;
      if (k == 5) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", busy8, 0);
    check("abort done", done8, 0);
    check("abort diff", diff8, 0);
    check("abort bout", bout8, 0);
    check("abort ov", ov8, 0);
    dones = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) dones++; end
    check("abort no_activity", dones, 0);
    op8("fresh", 8'h33, 8'h44, 1'b1, 8'hEE, 1'b1, 1'b0, 0);

    op32(0, 32'h8000_0000, 32'h0000_0001, 1'b0);
    op32(1, 32'h0000_0000, 32'h0000_0000, 1'b1);
    for (int i = 2; i < 200; i++) op32(i, $urandom, $urandom, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
